skinny_round_sequencer: RTL and testbench

- Sequences one tweakable block-cipher call on the Romulus-N datapath.
- On a start request it issues one load strobe, then steps the unrolled SKINNY-128-384+ round core for NUM_ROUNDS/RPC cycles, supplying RPC round constants per cycle, then reports completion.
- It also owns the 56-bit Romulus block-counter LFSR consumed as tweak.
- It sits between the API controller, which requests and increments, and the mode datapath, which consumes the enables, constants and counter.

---
 rtl/romulus_ctrl_pkg.sv | 36 +++
 rtl/skinny_rc_lfsr.sv | 42 ++++
 rtl/skinny_round_sequencer.sv | 123 ++++++++++++
 tb/tb_skinny_round_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/romulus_ctrl_pkg.sv
// Shared definitions for the Romulus-N cipher-call sequencer: FSM state
// encoding, the SKINNY 6-bit round-constant step, and the 56-bit block
// counter LFSR (x^56+x^7+x^4+x^2+1) with its init value.
package romulus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_NUM_ROUNDS = 40;

  // Block counter
  localparam int CNT_W     = 56;
  localparam int CNT_TAP_A = 2;
  localparam int CNT_TAP_B = 4;
  localparam int CNT_TAP_C = 7;
  localparam logic [CNT_W-1:0] CNT_INIT = 56'h1;
  localparam logic [CNT_W-1:0] CNT_TAP_MASK = (CNT_W'(1) << CNT_TAP_A)
                                            | (CNT_W'(1) << CNT_TAP_B)
                                            | (CNT_W'(1) << CNT_TAP_C);

  // One step of the SKINNY round-constant LFSR.
  function automatic logic [5:0] rc_step(input logic [5:0] r);
    return {r[4:0], r[5] ^ r[4] ^ 1'b1};
  endfunction

  // One step of the block counter: rotate left, and the bit falling out of
  // the top is folded back into the tap positions.
  function automatic logic [CNT_W-1:0] ctr_step(input logic [CNT_W-1:0] c);
    return {c[CNT_W-2:0], c[CNT_W-1]} ^ (c[CNT_W-1] ? CNT_TAP_MASK : '0);
  endfunction

endpackage

// File: rtl/skinny_rc_lfsr.sv
// SKINNY round-constant generator for an RPC-way unrolled round core.
// Ports:
//   clk, rst  - clock, async active-high reset (register -> 0)
//   clr       - clear register to 0 (start of a cipher call)
//   adv       - advance register by RPC steps
//   rc_bus    - slice k = register stepped k+1 times (constant of the k-th
//               round executed this cycle)
module skinny_rc_lfsr
  import romulus_ctrl_pkg::*;
#(
  parameter int RPC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [6*RPC-1:0] rc_bus
);

  logic [5:0] rc_q, rc_d;
  logic [5:0] chain [RPC+1];

  assign chain[0] = rc_q;

  for (genvar k = 0; k < RPC; k++) begin : g_step
    assign chain[k+1]       = rc_step(chain[k]);
    assign rc_bus[6*k +: 6] = chain[k+1];
  end

  // The last slice of this cycle is exactly where the next cycle starts.
  always_comb begin
    rc_d = rc_q;
    if (clr)      rc_d = '0;
    else if (adv) rc_d = chain[RPC];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rc_q <= '0;
    else     rc_q <= rc_d;
  end

endmodule

// File: rtl/skinny_round_sequencer.sv
// Sequences one SKINNY-128-384+ call on the Romulus-N datapath: a load
// strobe, NUM_ROUNDS/RPC round-enable cycles with RPC round constants each,
// then a done pulse. Also owns the 56-bit Romulus block counter.
// Ports:
//   clk, rst           - clock, async active-high reset
//   start              - request a call (sampled in IDLE only)
//   busy               - LOAD/RUN/DONE
//   load_en            - one-cycle datapath load strobe
//   round_en           - datapath registers RPC rounds this cycle
//   last_round         - final RUN cycle
//   done               - one-cycle completion pulse
//   rc                 - RPC packed 6-bit round constants (0 outside RUN)
//   cnt_init, cnt_inc  - counter init (wins) / one LFSR step
//   counter            - current block counter
module skinny_round_sequencer
  import romulus_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int RPC        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             load_en,
  output logic             round_en,
  output logic             last_round,
  output logic             done,
  output logic [6*RPC-1:0] rc,
  input  logic             cnt_init,
  input  logic             cnt_inc,
  output logic [CNT_W-1:0] counter
);

  localparam int RUN_CYC = NUM_ROUNDS / RPC;
  // One extra code point so the count can step past the last RUN cycle
  // without wrapping.
  localparam int RCNT_W  = $clog2(RUN_CYC + 1);
  localparam logic [RCNT_W-1:0] LAST_CNT = RCNT_W'(RUN_CYC - 1);

  state_e              state_q, state_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic                busy_q, busy_d;
  logic                load_en_q, load_en_d;
  logic                round_en_q, round_en_d;
  logic                last_round_q, last_round_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [6*RPC-1:0]    rc_bus;

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        rcnt_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        rcnt_d = rcnt_q + RCNT_W'(1);
        if (rcnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d       = (state_d != ST_IDLE);
    load_en_d    = (state_d == ST_LOAD);
    round_en_d   = (state_d == ST_RUN);
    last_round_d = (state_d == ST_RUN) && (rcnt_d == LAST_CNT);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rcnt_q       <= '0;
      busy_q       <= 1'b0;
      load_en_q    <= 1'b0;
      round_en_q   <= 1'b0;
      last_round_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      busy_q       <= busy_d;
      load_en_q    <= load_en_d;
      round_en_q   <= round_en_d;
      last_round_q <= last_round_d;
      done_q       <= done_d;
    end
  end

  skinny_rc_lfsr #(.RPC(RPC)) u_rc (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_LOAD),
    .adv    (state_q == ST_RUN),
    .rc_bus (rc_bus)
  );

  // Block counter runs independently of the FSM.
  always_comb begin
    counter_d = counter_q;
    if (cnt_init)     counter_d = CNT_INIT;
    else if (cnt_inc) counter_d = ctr_step(counter_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) counter_q <= CNT_INIT;
    else     counter_q <= counter_d;
  end

  assign busy       = busy_q;
  assign load_en    = load_en_q;
  assign round_en   = round_en_q;
  assign last_round = last_round_q;
  assign done       = done_q;
  assign rc         = (state_q == ST_RUN) ? rc_bus : '0;
  assign counter    = counter_q;

endmodule

// File: tb/tb_skinny_round_sequencer.sv
module tb_skinny_round_sequencer;

  localparam int NR   = 40;
  localparam int RPC  = 4;
  localparam int NCYC = NR / RPC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, cnt_init = 1'b0, cnt_inc = 1'b0;
  logic busy, load_en, round_en, last_round, done;
  logic [6*RPC-1:0] rc;
  logic [55:0] counter;

  logic start8 = 1'b0, zero8 = 1'b0;
  logic busy8, load_en8, round_en8, last_round8, done8;
  logic [47:0] rc8;
  logic [55:0] counter8;

  always #5 clk = ~clk;

  skinny_round_sequencer #(.NUM_ROUNDS(NR), .RPC(RPC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .load_en(load_en),
    .round_en(round_en), .last_round(last_round), .done(done), .rc(rc),
    .cnt_init(cnt_init), .cnt_inc(cnt_inc), .counter(counter)
  );

  skinny_round_sequencer #(.NUM_ROUNDS(40), .RPC(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .load_en(load_en8),
    .round_en(round_en8), .last_round(last_round8), .done(done8), .rc(rc8),
    .cnt_init(zero8), .cnt_inc(zero8), .counter(counter8)
  );

  typedef struct packed {
    logic        busy;
    logic        load_en;
    logic        round_en;
    logic        last_round;
    logic        done;
    logic [23:0] rc;
  } obs_t;

  obs_t        exp_q[$];
  logic [55:0] cnt_m = 56'h1;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [5:0] rc6(input logic [5:0] r);
    return {r[4:0], ~(r[5] ^ r[4])};
  endfunction

  // Constants for RUN cycle j (0-based): continue from 0 by j*RPC steps.
  function automatic logic [23:0] model_rc(input int j);
    logic [5:0]  r;
    logic [23:0] v;
    r = '0;
    v = '0;
    for (int s = 0; s < j * RPC; s++) r = rc6(r);
    for (int k = 0; k < RPC; k++) begin
      r = rc6(r);
      v[6*k +: 6] = r;
    end
    return v;
  endfunction

  // Expected outputs in cycle c of a call (c=1 is the load cycle).
  function automatic obs_t rec(input int c);
    obs_t o;
    o.busy       = (c >= 1) && (c <= NCYC + 2);
    o.load_en    = (c == 1);
    o.round_en   = (c >= 2) && (c <= NCYC + 1);
    o.last_round = (c == NCYC + 1);
    o.done       = (c == NCYC + 2);
    o.rc         = o.round_en ? model_rc(c - 2) : 24'h0;
    return o;
  endfunction

  function automatic logic [55:0] cnt_step(input logic [55:0] c);
    logic [55:0] n;
    for (int i = 0; i < 56; i++) begin
      if (i == 0) n[i] = c[55];
      else        n[i] = c[i-1] ^ (((i == 2) || (i == 4) || (i == 7)) & c[55]);
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic push_call();
    for (int c = 1; c <= NCYC + 2; c++) exp_q.push_back(rec(c));
    exp_q.push_back('0);  // mandatory idle cycle after done
  endtask

  task automatic check_obs(input string tag, input obs_t e);
    obs_t o;
    o = {busy, load_en, round_en, last_round, done, rc};
    chk(tag, 64'(o), 64'(e));
    chk({tag, "_cnt"}, 64'(counter), 64'(cnt_m));
  endtask

  task automatic check_now(input string tag);
    check_obs(tag, '0);
  endtask

  // Advance one clock, update the models from the inputs seen at the edge,
  // then compare against the scoreboard (empty scoreboard = idle).
  task automatic tick(input string tag);
    logic st, ci, cn;
    obs_t e;
    st = start;
    ci = cnt_init;
    cn = cnt_inc;
    @(posedge clk);
    if (ci)      cnt_m = 56'h1;
    else if (cn) cnt_m = cnt_step(cnt_m);
    if (st && exp_q.size() == 0) push_call();
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : obs_t'('0);
    check_obs(tag, e);
  endtask

  task automatic run_nominal(input string tag, input bit toggle);
    start = 1'b1;
    tick(tag);
    start = 1'b0;
    for (int c = 2; c <= NCYC + 3; c++) begin
      start = toggle && (c >= 3) && (c <= NCYC + 2) && (c % 2 == 1);
      tick(tag);
      if (c == 2)
        chk({tag, "_rc_c2"}, 64'(rc), 64'({6'h0F, 6'h07, 6'h03, 6'h01}));
      if (c == 3)
        chk({tag, "_rc_c3"}, 64'(rc), 64'({6'h3B, 6'h3D, 6'h3E, 6'h1F}));
      if (c == NCYC + 1)
        chk({tag, "_rc_last"}, 64'(rc[23:18]), 64'(6'h1A));
      if (c == NCYC + 2)
        chk({tag, "_done"}, 64'(done), 64'(1'b1));
    end
    start = 1'b0;
  endtask

  initial begin : main
    int nloads, ndones, load2, done1;
    nloads = 0; ndones = 0; load2 = 0; done1 = 0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    check_now("reset");
    rst = 1'b0;
    tick("idle0");

    // nominal call
    run_nominal("nom", 1'b0);

    // counter walk
    cnt_inc = 1'b1;
    repeat (55) tick("cnt_walk");
    cnt_inc = 1'b0;
    chk("cnt_top", 64'(counter), 64'(56'h80_0000_0000_0000));
    cnt_inc = 1'b1;
    tick("cnt_wrap");
    cnt_inc = 1'b0;
    chk("cnt_95", 64'(counter), 64'(56'h95));
    cnt_init = 1'b1;
    cnt_inc  = 1'b1;
    tick("cnt_init");
    cnt_init = 1'b0;
    cnt_inc  = 1'b0;
    chk("cnt_init_wins", 64'(counter), 64'(56'h1));
    cnt_inc = 1'b1;
    repeat (3) tick("cnt_pre");
    cnt_inc = 1'b0;

    // start held high
    start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick("held");
      if (load_en) begin
        nloads++;
        if (nloads == 2) load2 = i;
      end
      if (done) begin
        ndones++;
        if (ndones == 1) done1 = i;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick("held_drain");
    chk("held_drained", 64'(exp_q.size()), 64'(0));
    chk("held_loads", 64'(nloads), 64'(3));
    chk("held_dones", 64'(ndones), 64'(2));
    chk("held_gap", 64'(load2 - done1), 64'(2));

    // RPC=8 instance
    start8 = 1'b1;
    tick("d8_go");
    start8 = 1'b0;
    chk("d8_load", 64'({busy8, load_en8, round_en8, last_round8, done8}), 64'(5'b11000));
    for (int c = 2; c <= 8; c++) begin
      tick("d8_idle_main");
      chk("d8_ctl", 64'({busy8, load_en8, round_en8, last_round8, done8}),
          64'({c <= 7, 1'b0, (c >= 2) && (c <= 6), c == 6, c == 7}));
      if (c == 2)
        chk("d8_rc_c2", 64'(rc8), 64'({6'h3B, 6'h3D, 6'h3E, 6'h1F,
                                         6'h0F, 6'h07, 6'h03, 6'h01}));
      if (c == 7) chk("d8_rc_off", 64'(rc8), 64'(0));
    end

    // async reset during RUN cycle 6
    start = 1'b1;
    tick("rr");
    start = 1'b0;
    repeat (5) tick("rr");
    chk("rr_in_run", 64'(round_en), 64'(1'b1));
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    cnt_m = 56'h1;
    check_now("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick("post_rst");
    run_nominal("recover", 1'b1);
    tick("end_idle");

    chk("d8_counter", 64'(counter8), 64'(56'h1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
